mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares both ports of the dual-port image/hash SRAM between NUM_REQ requesters
//  (0=buffer loader, 1=hash engine, 2=reorder engine). Per-port round-robin with optional burst lock.
//  Registers SRAM controls and routes read data back with a valid strobe.
//  Replaces static per-phase muxing; the phase sequencer only drives req_mask.
// PARAMETERS
//  NUM_REQ   3    number of requesters
//  ADDR_W    12   SRAM address width
//  DATA_W    32   SRAM data width
//  LOCK_MAX  64   max consecutive locked grants before forced re-arbitration
// PORTS (x = 1,2 : one set per SRAM port; [N] = NUM_REQ-wide; [N][W] = packed per-requester array)
//  clk          in   1        single clock, all logic on posedge
//  reset        in   1        asynchronous, active-low reset (0 = in reset)
//  req_mask     in   N        per-requester enable from phase sequencer (1 = may access)
//  rq_req_x     in   N        access request, held until granted
//  rq_web_x     in   N        0 = write, 1 = read
//  rq_lock_x    in   N        keep grant next cycle (burst)
//  rq_addr_x    in   N*ADDR_W request address
//  rq_wdata_x   in   N*DATA_W write data
//  rq_gnt_x     out  N        one-hot grant, combinational; req&gnt = accepted
//  rq_rvalid_x  out  N        one-hot read-data valid
//  rq_rdata_x   out  DATA_W   read data (broadcast; qualify with rvalid)
//  mem_A_x      out  ADDR_W   SRAM address       mem_I_x  out DATA_W  SRAM write data
//  mem_WEB_x    out  1        SRAM write enable, active-low
//  mem_CSB_x    out  1        SRAM chip select, active-low
//  mem_OEB_x    out  1        SRAM output enable, active-low
//  mem_O_x      in   DATA_W   SRAM read data
//  busy         out  1        any access issued or read in flight
//  collision_err out 1        sticky: same-address dual write seen
// BEHAVIOUR
//  Reset values: CSB=1, WEB=1, OEB=1, A=0, I=0, gnt=0, rvalid=0, collision_err=0.
//   Pointers = NUM_REQ-1; lock cleared. Reset mid-operation drops in-flight reads (no rvalid).
//  Arbitration (per port, cycle t): elig = req & req_mask.
//   Lock held and owner still elig with lock=1 -> owner granted. Otherwise search ptr+1, ptr+2, ...
//   mod NUM_REQ; first elig wins. ptr <= winner on accept. Grant never goes to a masked requester.
//  Lock: set when accepted with lock=1; ptr frozen while locked.
//   Released when owner drops req, lock or mask; lock_cnt resets on release.
//   After LOCK_MAX consecutive locked accepts, arbitration for that cycle ignores lock; lock_cnt clears.
//  Issue: accept in cycle t -> edge t+1 registers A, I, WEB=rq_web, CSB=0, OEB=~rq_web.
//   No accept -> CSB=1, WEB=1, OEB=1; A and I hold.
//  Read return: mem_O valid in cycle t+2. 2-deep {id,is_read} tag pipe drives rvalid[id]=1 in t+2.
//   rdata = mem_O_x (passthrough). Back-to-back reads: one per cycle per port, full throughput.
//  Collision: both ports accept writes to equal addresses in the same cycle ->
//   port 2 still granted, but its issue is suppressed (CSB2=1); collision_err <= 1 until reset.
//   Read/write same address across ports: not flagged.
//  Width: addresses passed unmodified, no wrap logic. lock_cnt is $clog2(LOCK_MAX+1) bits, saturates.
// STRUCTURE
//  mem_arb_pkg: ADDR_W/DATA_W defaults, REQ_BUF/REQ_HASH/REQ_REORDER ids, req_id_t, tag_t struct.
//  Sub-module rr_lock_arb (elig, lock, ptr, lock_cnt -> gnt) instantiated once per port.
//  Top level holds issue registers, tag pipes, collision check.
// TESTING
//  1 Reset: hold reset=0, random req -> all gnt=0, CSB=1/WEB=1/OEB=1; release -> first grant goes to req 0.
//  2 RR: req=3'b111 on port 1 for 6 cycles, mask=111 -> grants 0,1,2,0,1,2; mem_A follows 1 cycle later.
//  3 Read latency: req1 reads 0x05A at t; mem_O=0xDEADBEEF at t+2 -> rvalid_1=3'b010 in t+2 only.
//  4 Lock: req2 lock=1 for 100 cycles, req0 also requesting, LOCK_MAX=64 ->
//    req0 granted exactly once after 64 req2 grants.
//  5 Mask: mask=3'b010 while req0 locked -> lock drops same cycle; gnt=3'b010 if req1 pending, else 0.
//  6 Collision: both ports write 0x123 same cycle -> CSB1=0, CSB2=1 next cycle; collision_err=1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths, requester ids and the read-return tag for the dual-port SRAM arbiter.
// Types and constants only, so there is no latency and no backpressure.
package mem_arb_pkg;
    localparam int MEM_ADDR_W  = 12;
    localparam int MEM_DATA_W  = 32;
    localparam int MEM_NUM_REQ = 3;
    localparam int REQ_ID_W    = $clog2(MEM_NUM_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_BUF     = 2'd0;
    localparam req_id_t REQ_HASH    = 2'd1;
    localparam req_id_t REQ_REORDER = 2'd2;

    typedef struct packed {
        req_id_t id;
        logic    is_read;
    } tag_t;
endpackage

// File: rtl/rr_lock_arb.sv
// Round-robin arbiter for one SRAM port, with a burst lock that is force-broken after LOCK_MAX grants.
// The grant is combinational from elig_i; the pointer and lock state update on the accepting edge.
module rr_lock_arb #(
    parameter int NUM_REQ  = 3,
    parameter int LOCK_MAX = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         elig_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] win_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic [ID_W-1:0]  ptr_q, owner_q, idx;
    logic             lock_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hold, forced, keep;

    always_comb begin
        hold   = lock_q && elig_i[owner_q] && lock_i[owner_q];
        forced = hold && (cnt_q >= CNT_MAX);
        keep   = hold && !forced;
        gnt_o  = '0;
        win_o  = ptr_q;
        idx    = '0;
        if (keep) begin
            gnt_o[owner_q] = 1'b1;
            win_o          = owner_q;
        end else begin
            // Walk from the farthest slot to the nearest so the nearest eligible requester is assigned last.
            for (int k = NUM_REQ; k >= 1; k--) begin
                idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                if (elig_i[idx]) begin
                    gnt_o      = '0;
                    gnt_o[idx] = 1'b1;
                    win_o      = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= ID_W'(NUM_REQ - 1);
            owner_q <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (|gnt_o) begin
            if (!keep) ptr_q <= win_o;
            if (lock_i[win_o]) begin
                lock_q  <= 1'b1;
                owner_q <= win_o;
                cnt_q   <= keep ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1) : CNT_W'(1);
            end else begin
                lock_q <= 1'b0;
                cnt_q  <= '0;
            end
        end else begin
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto both SRAM ports, registers the SRAM controls and returns read data with rvalid.
// Grant is combinational and a request waits (held) until granted; controls follow 1 cycle later, rvalid 2 cycles later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = MEM_NUM_REQ,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int LOCK_MAX = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_mask,
    input  logic [NUM_REQ-1:0]             rq_req_1,
    input  logic [NUM_REQ-1:0]             rq_web_1,
    input  logic [NUM_REQ-1:0]             rq_lock_1,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] rq_addr_1,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] rq_wdata_1,
    output logic [NUM_REQ-1:0]             rq_gnt_1,
    output logic [NUM_REQ-1:0]             rq_rvalid_1,
    output logic [DATA_W-1:0]              rq_rdata_1,
    output logic [ADDR_W-1:0]              mem_A_1,
    output logic [DATA_W-1:0]              mem_I_1,
    output logic                           mem_WEB_1,
    output logic                           mem_CSB_1,
    output logic                           mem_OEB_1,
    input  logic [DATA_W-1:0]              mem_O_1,
    input  logic [NUM_REQ-1:0]             rq_req_2,
    input  logic [NUM_REQ-1:0]             rq_web_2,
    input  logic [NUM_REQ-1:0]             rq_lock_2,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] rq_addr_2,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] rq_wdata_2,
    output logic [NUM_REQ-1:0]             rq_gnt_2,
    output logic [NUM_REQ-1:0]             rq_rvalid_2,
    output logic [DATA_W-1:0]              rq_rdata_2,
    output logic [ADDR_W-1:0]              mem_A_2,
    output logic [DATA_W-1:0]              mem_I_2,
    output logic                           mem_WEB_2,
    output logic                           mem_CSB_2,
    output logic                           mem_OEB_2,
    input  logic [DATA_W-1:0]              mem_O_2,
    output logic                           busy,
    output logic                           collision_err
);
    localparam int NP = 2;

    logic [NUM_REQ-1:0]             req [NP], web [NP], lck [NP], arb_gnt [NP], gnt [NP], rvld [NP];
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr [NP];
    logic [NUM_REQ-1:0][DATA_W-1:0] wdat [NP];
    req_id_t                        win [NP];
    logic                           acc [NP], wr [NP], issue [NP];
    logic                           collide;

    logic [ADDR_W-1:0] a_q [NP];
    logic [DATA_W-1:0] i_q [NP];
    logic              web_q [NP], csb_q [NP], oeb_q [NP];
    tag_t              tag1_q [NP], tag2_q [NP];
    logic              coll_q;

    assign req[0]  = rq_req_1;   assign req[1]  = rq_req_2;
    assign web[0]  = rq_web_1;   assign web[1]  = rq_web_2;
    assign lck[0]  = rq_lock_1;  assign lck[1]  = rq_lock_2;
    assign addr[0] = rq_addr_1;  assign addr[1] = rq_addr_2;
    assign wdat[0] = rq_wdata_1; assign wdat[1] = rq_wdata_2;

    for (genvar p = 0; p < NP; p++) begin : g_port
        rr_lock_arb #(
            .NUM_REQ  (NUM_REQ),
            .LOCK_MAX (LOCK_MAX)
        ) u_arb (
            .clk    (clk),
            .reset  (reset),
            .elig_i (req[p] & req_mask),
            .lock_i (lck[p]),
            .gnt_o  (arb_gnt[p]),
            .win_o  (win[p])
        );
        // Grants stay low while reset is held, even though the arbiter itself is combinational.
        assign gnt[p] = arb_gnt[p] & {NUM_REQ{reset}};
        assign acc[p] = |gnt[p];
        assign wr[p]  = acc[p] & ~web[p][win[p]];
    end

    // A same-address dual write keeps port 1's access and silently drops port 2's issue.
    assign collide  = wr[0] & wr[1] & (addr[0][win[0]] == addr[1][win[1]]);
    assign issue[0] = acc[0];
    assign issue[1] = acc[1] & ~collide;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rvld[p] = '0;
            if (tag2_q[p].is_read) rvld[p][tag2_q[p].id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                a_q[p]    <= '0;
                i_q[p]    <= '0;
                web_q[p]  <= 1'b1;
                csb_q[p]  <= 1'b1;
                oeb_q[p]  <= 1'b1;
                tag1_q[p] <= '0;
                tag2_q[p] <= '0;
            end
            coll_q <= 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                tag2_q[p] <= tag1_q[p];
                if (issue[p]) begin
                    a_q[p]    <= addr[p][win[p]];
                    i_q[p]    <= wdat[p][win[p]];
                    web_q[p]  <= web[p][win[p]];
                    csb_q[p]  <= 1'b0;
                    oeb_q[p]  <= ~web[p][win[p]];
                    tag1_q[p] <= '{id: win[p], is_read: web[p][win[p]]};
                end else begin
                    web_q[p]  <= 1'b1;
                    csb_q[p]  <= 1'b1;
                    oeb_q[p]  <= 1'b1;
                    tag1_q[p] <= '0;
                end
            end
            if (collide) coll_q <= 1'b1;
        end
    end

    assign rq_gnt_1    = gnt[0];    assign rq_gnt_2    = gnt[1];
    assign rq_rvalid_1 = rvld[0];   assign rq_rvalid_2 = rvld[1];
    assign rq_rdata_1  = mem_O_1;   assign rq_rdata_2  = mem_O_2;
    assign mem_A_1     = a_q[0];    assign mem_A_2     = a_q[1];
    assign mem_I_1     = i_q[0];    assign mem_I_2     = i_q[1];
    assign mem_WEB_1   = web_q[0];  assign mem_WEB_2   = web_q[1];
    assign mem_CSB_1   = csb_q[0];  assign mem_CSB_2   = csb_q[1];
    assign mem_OEB_1   = oeb_q[0];  assign mem_OEB_2   = oeb_q[1];

    assign busy = ~csb_q[0] | ~csb_q[1] | tag1_q[0].is_read | tag1_q[1].is_read
                | tag2_q[0].is_read | tag2_q[1].is_read;
    assign collision_err = coll_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, then random traffic vs a rule-level model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [2:0]       req_mask;
    logic [2:0]       rq_req_1, rq_web_1, rq_lock_1, rq_req_2, rq_web_2, rq_lock_2;
    logic [2:0][11:0] rq_addr_1, rq_addr_2;
    logic [2:0][31:0] rq_wdata_1, rq_wdata_2;
    logic [2:0]       rq_gnt_1, rq_rvalid_1, rq_gnt_2, rq_rvalid_2;
    logic [31:0]      rq_rdata_1, rq_rdata_2, mem_I_1, mem_I_2, mem_O_1, mem_O_2;
    logic [11:0]      mem_A_1, mem_A_2;
    logic             mem_WEB_1, mem_CSB_1, mem_OEB_1, mem_WEB_2, mem_CSB_2, mem_OEB_2;
    logic             busy, collision_err;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset), .req_mask(req_mask),
        .rq_req_1(rq_req_1), .rq_web_1(rq_web_1), .rq_lock_1(rq_lock_1),
        .rq_addr_1(rq_addr_1), .rq_wdata_1(rq_wdata_1), .rq_gnt_1(rq_gnt_1),
        .rq_rvalid_1(rq_rvalid_1), .rq_rdata_1(rq_rdata_1), .mem_A_1(mem_A_1),
        .mem_I_1(mem_I_1), .mem_WEB_1(mem_WEB_1), .mem_CSB_1(mem_CSB_1),
        .mem_OEB_1(mem_OEB_1), .mem_O_1(mem_O_1),
        .rq_req_2(rq_req_2), .rq_web_2(rq_web_2), .rq_lock_2(rq_lock_2),
        .rq_addr_2(rq_addr_2), .rq_wdata_2(rq_wdata_2), .rq_gnt_2(rq_gnt_2),
        .rq_rvalid_2(rq_rvalid_2), .rq_rdata_2(rq_rdata_2), .mem_A_2(mem_A_2),
        .mem_I_2(mem_I_2), .mem_WEB_2(mem_WEB_2), .mem_CSB_2(mem_CSB_2),
        .mem_OEB_2(mem_OEB_2), .mem_O_2(mem_O_2),
        .busy(busy), .collision_err(collision_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_mask = 3'b111;
        rq_req_1 = '0; rq_web_1 = 3'b111; rq_lock_1 = '0; rq_addr_1 = '0; rq_wdata_1 = '0;
        rq_req_2 = '0; rq_web_2 = 3'b111; rq_lock_2 = '0; rq_addr_2 = '0; rq_wdata_2 = '0;
        mem_O_1 = '0; mem_O_2 = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference model: per-port pointer, lock owner and consecutive-locked-grant count.
    int         m_ptr [2], m_owner [2], m_cnt [2];
    bit         m_locked [2];
    bit         m_sticky;
    logic [11:0] e_a [2];
    logic       e_csb [2], e_web [2], e_oeb [2];
    logic [2:0] rv_d1 [2], rv_d2 [2];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_ptr[p] = 2; m_owner[p] = 0; m_cnt[p] = 0; m_locked[p] = 0;
            e_a[p] = '0; e_csb[p] = 1; e_web[p] = 1; e_oeb[p] = 1;
            rv_d1[p] = '0; rv_d2[p] = '0;
        end
        m_sticky = 0;
    endtask

    task automatic arb_model(input int p, input logic [2:0] elig, input logic [2:0] lk, output int win);
        bit stay;
        stay = m_locked[p] && elig[m_owner[p]] && lk[m_owner[p]] && (m_cnt[p] < 64);
        win = -1;
        if (stay) win = m_owner[p];
        else begin
            for (int k = 1; k <= 3; k++)
                if (win < 0 && elig[(m_ptr[p] + k) % 3]) win = (m_ptr[p] + k) % 3;
        end
        if (win >= 0 && lk[win]) begin
            m_cnt[p]    = stay ? m_cnt[p] + 1 : 1;
            m_locked[p] = 1;
            m_owner[p]  = win;
        end else begin
            m_cnt[p]    = 0;
            m_locked[p] = 0;
        end
        if (win >= 0) m_ptr[p] = win;
    endtask

    typedef struct {
        logic [2:0] mask;
        logic [2:0] req;
        logic [2:0] gnt;
    } vec_t;
    vec_t vt [12];

    initial begin
        logic [11:0] pa;
        logic        pcsb;
        int          c2, c0, before0, w0, w1;
        bit          got0, coll;
        logic [2:0]  g0, g1, nrv0, nrv1;

        vt[0]  = '{3'b111, 3'b111, 3'b001};
        vt[1]  = '{3'b111, 3'b111, 3'b010};
        vt[2]  = '{3'b111, 3'b111, 3'b100};
        vt[3]  = '{3'b111, 3'b111, 3'b001};
        vt[4]  = '{3'b111, 3'b111, 3'b010};
        vt[5]  = '{3'b111, 3'b111, 3'b100};
        vt[6]  = '{3'b101, 3'b111, 3'b001};
        vt[7]  = '{3'b001, 3'b110, 3'b000};
        vt[8]  = '{3'b111, 3'b100, 3'b100};
        vt[9]  = '{3'b111, 3'b011, 3'b001};
        vt[10] = '{3'b111, 3'b101, 3'b100};
        vt[11] = '{3'b010, 3'b111, 3'b010};

        // Reset held with random requests.
        reset = 1'b1;
        idle();
        #2 reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            rq_req_1 = 3'($urandom); rq_req_2 = 3'($urandom | 1);
            rq_lock_1 = 3'($urandom); rq_web_1 = 3'($urandom);
            #4;
            chk("rst gnt1", rq_gnt_1, 0);
            chk("rst gnt2", rq_gnt_2, 0);
            chk("rst ctl1 csb/web/oeb", {mem_CSB_1, mem_WEB_1, mem_OEB_1}, 3'b111);
            chk("rst ctl2 csb/web/oeb", {mem_CSB_2, mem_WEB_2, mem_OEB_2}, 3'b111);
            chk("rst A1/I1", {mem_A_1, mem_I_1}, 0);
            chk("rst rvalid/err", {rq_rvalid_1, rq_rvalid_2, collision_err}, 0);
            tick();
        end
        idle();
        reset = 1'b1;

        // Round-robin and mask vectors on port 1; mem_A follows one cycle later.
        for (int r = 0; r < 3; r++) rq_addr_1[r] = 12'h100 + 12'(r);
        pa = '0; pcsb = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_mask = vt[i].mask; rq_req_1 = vt[i].req;
            #4;
            chk($sformatf("vec%0d gnt", i), rq_gnt_1, vt[i].gnt);
            chk($sformatf("vec%0d A", i), mem_A_1, pa);
            chk($sformatf("vec%0d CSB", i), mem_CSB_1, pcsb);
            if (vt[i].gnt != 0) begin
                pa   = vt[i].gnt[0] ? 12'h100 : (vt[i].gnt[1] ? 12'h101 : 12'h102);
                pcsb = 1'b0;
            end else pcsb = 1'b1;
            tick();
        end

        // Read latency on port 1.
        do_reset();
        rq_req_1 = 3'b010; rq_addr_1[1] = 12'h05A;
        #4 chk("rd gnt", rq_gnt_1, 3'b010);
        tick();
        rq_req_1 = '0;
        #4;
        chk("rd issue A", mem_A_1, 12'h05A);
        chk("rd issue csb/web/oeb", {mem_CSB_1, mem_WEB_1, mem_OEB_1}, 3'b010);
        chk("rd t+1 rvalid", rq_rvalid_1, 0);
        chk("rd busy", busy, 1);
        tick();
        mem_O_1 = 32'hDEADBEEF;
        #4;
        chk("rd t+2 rvalid", rq_rvalid_1, 3'b010);
        chk("rd t+2 rdata", rq_rdata_1, 32'hDEADBEEF);
        tick();
        #4 chk("rd t+3 rvalid", rq_rvalid_1, 0);
        tick();
        // Reset while a read is in flight drops its rvalid.
        rq_req_1 = 3'b100;
        tick();
        rq_req_1 = '0;
        reset = 1'b0;
        #2 reset = 1'b1;
        tick();
        #4 chk("rst drops rvalid", rq_rvalid_1, 0);
        tick();

        // Lock limit on port 2.
        do_reset();
        rq_lock_2 = 3'b100;
        c2 = 0; c0 = 0; before0 = -1; got0 = 0;
        for (int c = 0; c < 100; c++) begin
            rq_req_2 = {1'b1, 1'b0, (c > 0) && !got0};
            #4;
            if (rq_gnt_2[2]) c2++;
            if (rq_gnt_2[0]) begin
                c0++;
                if (before0 < 0) before0 = c2;
                got0 = 1;
            end
            tick();
        end
        chk("lock req0 grants", c0, 1);
        chk("lock req2 grants before req0", before0, 64);
        chk("lock total grants", c0 + c2, 100);

        // Mask drop while req0 holds the lock, with and without req1 pending.
        do_reset();
        rq_req_1 = 3'b001; rq_lock_1 = 3'b001;
        #4 chk("mask lock acquire", rq_gnt_1, 3'b001);
        tick();
        rq_req_1 = 3'b011;
        #4 chk("mask lock hold", rq_gnt_1, 3'b001);
        tick();
        req_mask = 3'b010;
        #4 chk("mask drop to req1", rq_gnt_1, 3'b010);
        tick();
        do_reset();
        rq_req_1 = 3'b001; rq_lock_1 = 3'b001;
        tick();
        req_mask = 3'b010;
        #4 chk("mask drop none", rq_gnt_1, 3'b000);
        tick();

        // Collision handling.
        do_reset();
        rq_req_1 = 3'b001; rq_addr_1[0] = 12'h123;
        rq_req_2 = 3'b010; rq_web_2 = 3'b101; rq_addr_2[1] = 12'h123;
        tick();
        idle();
        #4 chk("rd/wr csb1,csb2,err", {mem_CSB_1, mem_CSB_2, collision_err}, 3'b000);
        tick();
        rq_req_1 = 3'b001; rq_web_1 = 3'b110; rq_addr_1[0] = 12'h123;
        rq_req_2 = 3'b010; rq_web_2 = 3'b101; rq_addr_2[1] = 12'h123;
        #4 chk("coll gnts", {rq_gnt_1, rq_gnt_2}, 6'b001_010);
        tick();
        idle();
        #4 chk("coll csb1,web1,csb2,err", {mem_CSB_1, mem_WEB_1, mem_CSB_2, collision_err}, 4'b0011);
        repeat (3) tick();
        #4 chk("coll err sticky", collision_err, 1);
        do_reset();
        #4 chk("coll err cleared", collision_err, 0);

        // Random traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            req_mask  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            rq_req_1  = 3'($urandom); rq_web_1 = 3'($urandom); rq_lock_1 = 3'($urandom | $urandom);
            rq_req_2  = 3'($urandom); rq_web_2 = 3'($urandom); rq_lock_2 = 3'($urandom | $urandom);
            for (int r = 0; r < 3; r++) begin
                rq_addr_1[r] = 12'h120 + 12'($urandom_range(0, 1));
                rq_addr_2[r] = 12'h120 + 12'($urandom_range(0, 1));
                rq_wdata_1[r] = $urandom; rq_wdata_2[r] = $urandom;
            end
            mem_O_1 = $urandom; mem_O_2 = $urandom;
            #4;
            arb_model(0, rq_req_1 & req_mask, rq_lock_1, w0);
            arb_model(1, rq_req_2 & req_mask, rq_lock_2, w1);
            g0 = (w0 >= 0) ? 3'(1 << w0) : 3'b000;
            g1 = (w1 >= 0) ? 3'(1 << w1) : 3'b000;
            chk("rand gnt1", rq_gnt_1, g0);
            chk("rand gnt2", rq_gnt_2, g1);
            chk("rand ctl1", {mem_CSB_1, mem_WEB_1, mem_OEB_1, mem_A_1}, {e_csb[0], e_web[0], e_oeb[0], e_a[0]});
            chk("rand ctl2", {mem_CSB_2, mem_WEB_2, mem_OEB_2, mem_A_2}, {e_csb[1], e_web[1], e_oeb[1], e_a[1]});
            chk("rand rvalid", {rq_rvalid_1, rq_rvalid_2}, {rv_d2[0], rv_d2[1]});
            if (rv_d2[0] != 0) chk("rand rdata1", rq_rdata_1, mem_O_1);
            chk("rand err", collision_err, m_sticky);
            chk("rand busy", busy, !e_csb[0] || !e_csb[1] || rv_d1[0] != 0 || rv_d1[1] != 0
                                   || rv_d2[0] != 0 || rv_d2[1] != 0);
            coll = (w0 >= 0) && (w1 >= 0) && !rq_web_1[w0] && !rq_web_2[w1]
                   && (rq_addr_1[w0] == rq_addr_2[w1]);
            if (coll) m_sticky = 1;
            nrv0 = '0; nrv1 = '0;
            if (w0 >= 0) begin
                e_a[0] = rq_addr_1[w0]; e_csb[0] = 0; e_web[0] = rq_web_1[w0]; e_oeb[0] = !rq_web_1[w0];
                if (rq_web_1[w0]) nrv0 = g0;
            end else begin
                e_csb[0] = 1; e_web[0] = 1; e_oeb[0] = 1;
            end
            if (w1 >= 0 && !coll) begin
                e_a[1] = rq_addr_2[w1]; e_csb[1] = 0; e_web[1] = rq_web_2[w1]; e_oeb[1] = !rq_web_2[w1];
                if (rq_web_2[w1]) nrv1 = g1;
            end else begin
                e_csb[1] = 1; e_web[1] = 1; e_oeb[1] = 1;
            end
            rv_d2[0] = rv_d1[0]; rv_d2[1] = rv_d1[1];
            rv_d1[0] = nrv0;     rv_d1[1] = nrv1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
